handshake_rr_arbiter: RTL and testbench

- Shares one downstream valid/ready channel among N_SRC upstream valid/ready sources using round-robin arbitration with bounded bursts.
- Sits between several source-side handshake slices and a single forward-registered channel toward the destination.
- The output stage is registered: `dst_vaild`/`dst_data_out` come from flops, and `src_ready` has a combinational path from `dst_ready`, the same as a forward-registered slice.

---
 rtl/handshake_rr_arbiter_pkg.sv | 16 +
 rtl/rr_priority_picker.sv | 33 +++
 rtl/handshake_rr_arbiter.sv | 128 ++++++++++++
 tb/tb_handshake_rr_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/handshake_rr_arbiter_pkg.sv
// Shared constants and helpers for the round-robin handshake arbiter.
package handshake_rr_arbiter_pkg;

  localparam int unsigned DefaultWidth    = 9;
  localparam int unsigned DefaultNSrc     = 4;
  localparam int unsigned DefaultMaxBurst = 8;

  localparam logic [0:0] StArb   = 1'b0;
  localparam logic [0:0] StGrant = 1'b1;

  // Index width that stays at least one bit wide.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set request searching upward from last_i+1, wrapping.
module rr_priority_picker
  import handshake_rr_arbiter_pkg::*;
#(
  parameter int unsigned N   = DefaultNSrc,
  parameter int unsigned IdW = clog2_min1(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IdW-1:0] last_i,
  output logic           found_o,
  output logic [IdW-1:0] pick_o
);

  logic [IdW-1:0] start;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;

  always_comb begin
    start = (32'(last_i) == N - 1) ? '0 : last_i + 1'b1;
    // Double-width copy shifted by start puts the search origin at bit 0.
    dbl     = {req_i, req_i} >> start;
    rot     = dbl[N-1:0];
    found_o = 1'b0;
    pick_o  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (rot[i] && !found_o) begin
        found_o = 1'b1;
        pick_o  = IdW'((32'(start) + i) % N);
      end
    end
  end

endmodule

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter sharing one forward-registered valid/ready channel among N_SRC sources.
module handshake_rr_arbiter
  import handshake_rr_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter int unsigned N_SRC     = DefaultNSrc,
  parameter int unsigned MAX_BURST = DefaultMaxBurst
) (
  input  logic                       clk,
  input  logic                       s_rst,
  input  logic [N_SRC-1:0]           src_vaild,
  input  logic [N_SRC*WIDTH-1:0]     src_data_in,
  output logic [N_SRC-1:0]           src_ready,
  output logic                       dst_vaild,
  output logic [WIDTH-1:0]           dst_data_out,
  input  logic                       dst_ready,
  output logic [$clog2(N_SRC)-1:0]   grant_id,
  output logic                       idle
);

  localparam int unsigned IdW  = $clog2(N_SRC);
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  logic [0:0]       state_q, state_d;
  logic [IdW-1:0]   grant_q, grant_d;
  logic [IdW-1:0]   last_q, last_d;
  logic [CntW-1:0]  beat_q, beat_d;
  logic             dvalid_q, dvalid_d;
  logic [WIDTH-1:0] ddata_q, ddata_d;

  logic             found;
  logic [IdW-1:0]   pick;
  logic             in_grant;
  logic             ready_g;
  logic             xfer;
  logic             release_g;
  logic [WIDTH-1:0] src_data [N_SRC];

  rr_priority_picker #(
    .N   (N_SRC),
    .IdW (IdW)
  ) u_picker (
    .req_i   (src_vaild),
    .last_i  (last_q),
    .found_o (found),
    .pick_o  (pick)
  );

  always_comb begin
    for (int unsigned i = 0; i < N_SRC; i++) begin
      src_data[i] = src_data_in[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    in_grant  = (state_q == StGrant);
    // Output slot is free when empty or being drained this cycle.
    ready_g   = !dvalid_q || dst_ready;
    xfer      = in_grant && src_vaild[grant_q] && ready_g;
    release_g = in_grant &&
                (!src_vaild[grant_q] || (xfer && (beat_q == CntW'(MAX_BURST - 1))));
    src_ready = '0;
    if (in_grant) begin
      src_ready[grant_q] = ready_g;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    beat_d  = beat_q;
    unique case (state_q)
      StArb: begin
        if (found) begin
          grant_d = pick;
          beat_d  = '0;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (xfer) begin
          beat_d = beat_q + 1'b1;
        end
        if (release_g) begin
          last_d  = grant_q;
          state_d = StArb;
        end
      end
      default: state_d = StArb;
    endcase
  end

  always_comb begin
    dvalid_d = dvalid_q;
    ddata_d  = ddata_q;
    if (xfer) begin
      dvalid_d = 1'b1;
      ddata_d  = src_data[grant_q];
    end else if (dvalid_q && dst_ready) begin
      dvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge s_rst) begin
    if (s_rst) begin
      state_q  <= StArb;
      grant_q  <= '0;
      last_q   <= IdW'(N_SRC - 1);
      beat_q   <= '0;
      dvalid_q <= 1'b0;
      ddata_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      beat_q   <= beat_d;
      dvalid_q <= dvalid_d;
      ddata_q  <= ddata_d;
    end
  end

  assign dst_vaild    = dvalid_q;
  assign dst_data_out = ddata_q;
  assign grant_id     = grant_q;
  assign idle         = (state_q == StArb) && !dvalid_q;

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Directed scoreboard bench for handshake_rr_arbiter.
module tb_handshake_rr_arbiter;

  localparam int unsigned WIDTH     = 9;
  localparam int unsigned N_SRC     = 4;
  localparam int unsigned MAX_BURST = 8;

  logic                   clk = 1'b0;
  logic                   s_rst;
  logic [N_SRC-1:0]       src_vaild;
  logic [N_SRC*WIDTH-1:0] src_data_in;
  logic [N_SRC-1:0]       src_ready;
  logic                   dst_vaild;
  logic [WIDTH-1:0]       dst_data_out;
  logic                   dst_ready;
  logic [1:0]             grant_id;
  logic                   idle;

  always #5 clk = ~clk;

  handshake_rr_arbiter #(
    .WIDTH     (WIDTH),
    .N_SRC     (N_SRC),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk          (clk),
    .s_rst        (s_rst),
    .src_vaild    (src_vaild),
    .src_data_in  (src_data_in),
    .src_ready    (src_ready),
    .dst_vaild    (dst_vaild),
    .dst_data_out (dst_data_out),
    .dst_ready    (dst_ready),
    .grant_id     (grant_id),
    .idle         (idle)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] sq0[$];
  logic [WIDTH-1:0] sq1[$];
  logic [WIDTH-1:0] sq2[$];
  logic [WIDTH-1:0] sq3[$];
  int               out_cyc[$];
  logic [1:0]       out_gnt[$];
  logic             hold_pend;
  logic [WIDTH-1:0] held;
  logic             rnd_mode;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_assert++;
    assert (obs === want)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  function automatic int sq_size(input int s);
    case (s)
      0: return sq0.size();
      1: return sq1.size();
      2: return sq2.size();
      default: return sq3.size();
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] sq_front(input int s);
    if (sq_size(s) == 0) return '0;
    case (s)
      0: return sq0[0];
      1: return sq1[0];
      2: return sq2[0];
      default: return sq3[0];
    endcase
  endfunction

  task automatic sq_push(input int s, input logic [WIDTH-1:0] d);
    case (s)
      0: sq0.push_back(d);
      1: sq1.push_back(d);
      2: sq2.push_back(d);
      default: sq3.push_back(d);
    endcase
  endtask

  task automatic sq_pop(input int s);
    logic [WIDTH-1:0] d;
    if (sq_size(s) > 0) begin
      case (s)
        0: d = sq0.pop_front();
        1: d = sq1.pop_front();
        2: d = sq2.pop_front();
        default: d = sq3.pop_front();
      endcase
    end
  endtask

  // Load n beats of source s (value = base + index) and record them as expected output.
  task automatic load(input int s, input int base, input int n, input bit expect_out);
    for (int i = 0; i < n; i++) begin
      sq_push(s, WIDTH'(base + i));
      if (expect_out) exp_q.push_back(WIDTH'(base + i));
    end
  endtask

  task automatic drive();
    for (int s = 0; s < int'(N_SRC); s++) begin
      src_vaild[s]                  = (sq_size(s) > 0);
      src_data_in[s*WIDTH +: WIDTH] = sq_front(s);
    end
    dst_ready = rnd_mode ? 1'($urandom_range(1, 0)) : 1'b1;
  endtask

  task automatic step();
    logic [N_SRC-1:0] acc;
    @(negedge clk);
    cyc++;
    chk("src_ready_onehot0", 32'($onehot0(src_ready)), 32'd1);
    if (hold_pend) begin
      chk("hold_valid", 32'(dst_vaild), 32'd1);
      chk("hold_data", 32'(dst_data_out), 32'(held));
    end
    if (dst_vaild && dst_ready) begin
      n_assert++;
      assert (exp_q.size() > 0)
      else begin
        n_fail++;
        $error("FAIL unexpected_beat: observed 0x%0h expected no beat", dst_data_out);
      end
      if (exp_q.size() > 0) chk("out_data", 32'(dst_data_out), 32'(exp_q.pop_front()));
      out_cyc.push_back(cyc);
      out_gnt.push_back(grant_id);
    end
    hold_pend = dst_vaild && !dst_ready;
    held      = dst_data_out;
    acc       = src_vaild & src_ready;
    @(posedge clk);
    #1;
    for (int s = 0; s < int'(N_SRC); s++) begin
      if (acc[s]) sq_pop(s);
    end
    drive();
  endtask

  task automatic clear_all();
    sq0.delete();
    sq1.delete();
    sq2.delete();
    sq3.delete();
    exp_q.delete();
    out_cyc.delete();
    out_gnt.delete();
    hold_pend = 1'b0;
  endtask

  task automatic do_reset();
    s_rst = 1'b1;
    clear_all();
    drive();
    step();
    step();
    s_rst = 1'b0;
  endtask

  task automatic drain(input string tag, input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      step();
      n++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int rem[N_SRC];
    int seq[N_SRC];
    int s;
    int n;

    s_rst     = 1'b1;
    rnd_mode  = 1'b0;
    hold_pend = 1'b0;
    held      = '0;
    drive();
    step();
    step();
    chk("reset_dst_vaild", 32'(dst_vaild), 32'd0);
    chk("reset_dst_data", 32'(dst_data_out), 32'd0);
    chk("reset_src_ready", 32'(src_ready), 32'd0);
    chk("reset_grant_id", 32'(grant_id), 32'd0);
    chk("reset_idle", 32'(idle), 32'd1);
    s_rst = 1'b0;

    // Single source, 12 beats: 8-beat burst, bubble, 4-beat burst.
    load(2, 'h100, 12, 1'b1);
    drive();
    drain("t1_drain", 60);
    chk("t1_beats", 32'(out_cyc.size()), 32'd12);
    if (out_cyc.size() == 12) begin
      chk("t1_burst_span", 32'(out_cyc[7] - out_cyc[0]), 32'd7);
      chk("t1_bubble", 32'(out_cyc[8] - out_cyc[7]), 32'd2);
      chk("t1_tail_span", 32'(out_cyc[11] - out_cyc[8]), 32'd3);
      chk("t1_first_grant", 32'(out_gnt[0]), 32'd2);
      chk("t1_regrant", 32'(out_gnt[8]), 32'd2);
    end

    // All four sources: grants 0,1,2,3,0 in 8-beat bursts.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      sq_push(0, WIDTH'(k));
      sq_push(0, WIDTH'(0));
    end
    sq0.delete();
    load(0, 'h000, 8, 1'b1);
    load(1, 'h040, 8, 1'b1);
    load(2, 'h080, 8, 1'b1);
    load(3, 'h0c0, 8, 1'b1);
    load(0, 'h008, 8, 1'b1);
    drive();
    drain("t2_drain", 100);
    chk("t2_beats", 32'(out_cyc.size()), 32'd40);
    if (out_cyc.size() == 40) begin
      for (int k = 0; k < 5; k++) chk("t2_grant_order", 32'(out_gnt[k*8]), 32'(k % 4));
      chk("t2_bubble", 32'(out_cyc[32] - out_cyc[31]), 32'd2);
    end

    // Random backpressure: scoreboard order follows the round-robin model.
    do_reset();
    for (int k = 0; k < int'(N_SRC); k++) begin
      load(k, k * 64, 20, 1'b0);
      rem[k] = 20;
      seq[k] = 0;
    end
    s = 0;
    while (rem[0] + rem[1] + rem[2] + rem[3] > 0) begin
      n = (rem[s] > int'(MAX_BURST)) ? int'(MAX_BURST) : rem[s];
      for (int k = 0; k < n; k++) begin
        exp_q.push_back(WIDTH'(s * 64 + seq[s]));
        seq[s]++;
      end
      rem[s] -= n;
      s = (s + 1) % int'(N_SRC);
    end
    rnd_mode = 1'b1;
    drive();
    repeat (300) step();
    rnd_mode = 1'b0;
    drive();
    drain("t3_drain", 200);
    chk("t3_sources_empty", 32'(sq_size(0) + sq_size(1) + sq_size(2) + sq_size(3)), 32'd0);

    // Early release: source 1 drops after 3 beats, source 3 pending.
    do_reset();
    load(1, 'h040, 3, 1'b1);
    load(3, 'h0c0, 2, 1'b1);
    drive();
    n = 0;
    while (src_vaild[1] && n < 40) begin
      step();
      n++;
    end
    chk("t4_drop_seen", 32'(src_vaild[1]), 32'd0);
    chk("t4_grant_at_drop", 32'(grant_id), 32'd1);
    step();
    chk("t4_arb_src_ready", 32'(src_ready), 32'd0);
    chk("t4_arb_idle", 32'(idle), 32'd1);
    step();
    chk("t4_grant3", 32'(grant_id), 32'd3);
    chk("t4_grant3_ready", 32'(src_ready), 32'h8);
    drain("t4_drain", 40);

    // Asynchronous reset while source 0 presents beat 4.
    do_reset();
    load(0, 'h000, 16, 1'b1);
    load(1, 'h040, 8, 1'b0);
    drive();
    n = 0;
    while (sq_size(0) > 12 && n < 40) begin
      step();
      n++;
    end
    chk("t5_beats_before_reset", 32'(sq_size(0)), 32'd12);
    chk("t5_pre_valid", 32'(dst_vaild), 32'd1);
    #2;
    s_rst = 1'b1;
    #1;
    chk("t5_rst_dst_vaild", 32'(dst_vaild), 32'd0);
    chk("t5_rst_src_ready", 32'(src_ready), 32'd0);
    chk("t5_rst_idle", 32'(idle), 32'd1);
    chk("t5_rst_grant_id", 32'(grant_id), 32'd0);
    clear_all();
    drive();
    step();
    step();
    s_rst = 1'b0;
    load(0, 'h030, 2, 1'b1);
    load(1, 'h070, 2, 1'b1);
    drive();
    step();
    chk("t5_grant0", 32'(grant_id), 32'd0);
    chk("t5_grant0_ready", 32'(src_ready), 32'h1);
    drain("t5_drain", 40);

    // Idle with no requests.
    repeat (3) step();
    repeat (20) begin
      step();
      chk("t6_idle", 32'(idle), 32'd1);
      chk("t6_src_ready", 32'(src_ready), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
